// File: rtl/pc_pkg.sv
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared next-PC select encoding and default vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_CALL   = 3'd2,
    PC_RET    = 3'd3,
    PC_TRAP   = 3'd4,
    PC_HOLD   = 3'd5
  } pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
// ============================================================================
//  Module   : return_stack
//  Purpose  : Circular return-address stack; a push when full overwrites the
//             oldest entry. Storage is not reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr names the next free slot; pointer wrap gives the circular overwrite
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!full) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program counter with trap/stall/ret/call/branch priority decode
//             and a return-address stack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  PC_STEP      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         trap,
  input  logic [PC_WIDTH-1:0]          branch_target,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow,
  output logic                         ras_overflow
);

  localparam logic [PC_WIDTH-1:0] c_step       = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] c_align_mask = ~(PC_WIDTH'(PC_STEP - 1));

  pc_sel_e             w_sel;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_pc_seq;
  logic [PC_WIDTH-1:0] w_target_aligned;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic                w_ras_full;
  logic                w_ras_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_underflow_evt;
  logic                w_overflow_evt;

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_underflow;
  logic                r_overflow;

  assign w_pc_seq         = r_pc + c_step;
  assign w_target_aligned = branch_target & c_align_mask;

  // A ret on an empty stack falls through to sequential and only raises the flag
  always_comb begin
    w_sel           = PC_SEQ;
    w_underflow_evt = 1'b0;
    if (trap) begin
      w_sel = PC_TRAP;
    end else if (stall) begin
      w_sel = PC_HOLD;
    end else if (ret) begin
      if (w_ras_empty) begin
        w_sel           = PC_SEQ;
        w_underflow_evt = 1'b1;
      end else begin
        w_sel = PC_RET;
      end
    end else if (call) begin
      w_sel = PC_CALL;
    end else if (branch) begin
      w_sel = PC_BRANCH;
    end
  end

  always_comb begin
    w_pc_next = w_pc_seq;
    case (w_sel)
      PC_TRAP:   w_pc_next = TRAP_VECTOR;
      PC_HOLD:   w_pc_next = r_pc;
      PC_RET:    w_pc_next = w_ras_top;
      PC_CALL:   w_pc_next = w_target_aligned;
      PC_BRANCH: w_pc_next = w_target_aligned;
      default:   w_pc_next = w_pc_seq;
    endcase
  end

  assign w_push         = (w_sel == PC_CALL);
  assign w_pop          = (w_sel == PC_RET);
  assign w_overflow_evt = w_push && w_ras_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= RESET_VECTOR;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_underflow_evt) r_underflow <= 1'b1;
      if (w_overflow_evt)  r_overflow  <= 1'b1;
    end
  end

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_seq),
    .top       (w_ras_top),
    .count     (ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  assign pc            = r_pc;
  assign ras_underflow = r_underflow;
  assign ras_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of the program counter and branch target.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential increment in bytes; power of two.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'h0, PC value on reset.
REQ-004 SHALL have parameter TRAP_VECTOR, default 32'h100, PC value loaded on trap.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port stall, input, 1, hold PC and RAS this cycle.
REQ-009 SHALL have port branch, input, 1, load branch_target.
REQ-010 SHALL have port call, input, 1, load branch_target and push return address.
REQ-011 SHALL have port ret, input, 1, load popped return address.
REQ-012 SHALL have port trap, input, 1, load TRAP_VECTOR.
REQ-013 SHALL have port branch_target, input, PC_WIDTH, target for branch/call.
REQ-014 SHALL have port pc, output, PC_WIDTH, current program counter (registered).
REQ-015 SHALL have port ras_count, output, $clog2(RAS_DEPTH)+1, valid RAS entries.
REQ-016 SHALL have port ras_underflow, output, 1, sticky: ret issued with empty RAS.
REQ-017 SHALL have port ras_overflow, output, 1, sticky: call issued with full RAS.

Function
REQ-018 SHALL apply per-cycle priority: trap > stall > ret > call > branch > sequential.
REQ-019 trap SHALL set pc <= TRAP_VECTOR next edge regardless of stall; RAS unchanged.
REQ-020 stall without trap SHALL hold pc, RAS contents, ras_count and flags; branch/call/ret ignored (not queued).
REQ-021 sequential SHALL set pc <= pc + PC_STEP, wrapping modulo 2^PC_WIDTH (all-ones region wraps to 0).
REQ-022 branch SHALL set pc <= branch_target with low $clog2(PC_STEP) bits forced to zero.
REQ-023 call SHALL set pc <= aligned branch_target and push pc + PC_STEP (wrapped) onto RAS, same edge.
REQ-024 call with ras_count == RAS_DEPTH SHALL overwrite oldest entry (circular), keep ras_count at RAS_DEPTH, set ras_overflow.
REQ-025 ret with ras_count > 0 SHALL set pc <= top entry and decrement ras_count, same edge.
REQ-026 ret with ras_count == 0 SHALL behave as sequential (pc + PC_STEP) and set ras_underflow.
REQ-027 ret and call asserted together SHALL perform ret only; call dropped.
REQ-028 branch and call asserted together SHALL perform call only (single push).
REQ-029 ras_underflow and ras_overflow SHALL clear only on reset.
REQ-030 Latency: any request sampled at edge N SHALL be visible on pc after edge N; no combinational path from inputs to outputs.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) set pc = RESET_VECTOR, ras_count = 0, ras_underflow = 0, ras_overflow = 0, RAS pointer = 0.
REQ-032 RAS entry storage SHALL NOT require reset; entries beyond ras_count are never read.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight request; first edge after release performs normal priority evaluation from RESET_VECTOR.

Structure
REQ-034 Shared package pc_pkg SHALL hold the next-PC select enum (PC_SEQ, PC_BRANCH, PC_CALL, PC_RET, PC_TRAP, PC_HOLD) and default vectors.
REQ-035 RAS SHALL be a sub-module return_stack (push, pop, top, count, full, empty, circular overwrite); pc_sequencer contains priority decode and PC register.

Verification
REQ-036 Reset release, no requests, 3 edges -> pc 0x0, 0x4, 0x8, 0xC.
REQ-037 pc=0x10, call target 0x203 -> pc 0x200, ras_count 1; next ret -> pc 0x14, ras_count 0.
REQ-038 Five nested calls, RAS_DEPTH=4 -> ras_overflow 1, ras_count 4; four rets return innermost four addresses; fifth ret -> pc+4, ras_underflow 1.
REQ-039 stall with branch 0x400 for 2 cycles -> pc unchanged; stall+trap -> pc 0x100.
REQ-040 PC_WIDTH=8, pc=0xFC sequential -> pc 0x00; call at 0xFC pushes 0x00.
REQ-041 reset_n pulsed low between edges during call -> pc 0x0, ras_count 0 without a clock edge.
